// File: rtl/conv_weight_bank.sv
// conv_weight_bank: double-buffered, run-time loadable weight store for the conv stage
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   load_start            pulse: (re)start loading the shadow bank from word 0
//   wr_valid/wr_ready     weight stream handshake, wr_data in filter,row,col,channel order
//   swap                  pulse: make a fully loaded shadow bank live
//   rd_req/rd_filt        read one kernel from the active bank
//   kern_valid/kern_data  registered kernel, word (r,c,ch) at ((r*K+c)*CH+ch)*WIDTH
//   bank_ready            shadow bank full, waiting for swap
//   active_bank           index of the live bank
//   err                   sticky: bad swap or out-of-range rd_filt; cleared by load_start
// Optional: define CONV_WEIGHT_BANK_CHKSUM_EN to add output chksum, the signed sum of
// all words accepted since the last load_start.
module conv_weight_bank #(
  parameter int WIDTH = 17,
  parameter int N_FILT = 4,
  parameter int K = 3,
  parameter int CH = 3,
  localparam int KW = K*K*CH,
  localparam int NW = N_FILT*KW,
  localparam int FW = (N_FILT > 1) ? $clog2(N_FILT) : 1,
  localparam int CW = $clog2(NW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                swap,
  input  logic                rd_req,
  input  logic [FW-1:0]       rd_filt,
  output logic                kern_valid,
  output logic [KW*WIDTH-1:0] kern_data,
  output logic                bank_ready,
  output logic                active_bank,
  output logic                err
`ifdef CONV_WEIGHT_BANK_CHKSUM_EN
  ,
  output logic [WIDTH+CW-1:0] chksum
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NW*WIDTH-1:0] bank [2];
  logic wr_en, do_swap, bad_filt;
  assign wr_en = wr_valid & wr_ready;
  // load_start outranks a same-cycle swap: the shadow is being refilled
  assign do_swap = swap & bank_ready & ~load_start;
  assign bad_filt = rd_req & (int'(rd_filt) >= N_FILT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    wr_ready = state == LOAD;
    bank_ready = state == FULL;
    state_n = load_start ? LOAD
            : (wr_en && cnt == CW'(NW-1)) ? FULL
            : do_swap ? IDLE
            : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      bank[0] <= '0;
      bank[1] <= '0;
      active_bank <= 1'b0;
      err <= 1'b0;
      kern_valid <= 1'b0;
      kern_data <= '0;
    end else begin
      cnt <= load_start ? '0 : wr_en ? cnt + 1'b1 : cnt;
      if (wr_en) bank[~active_bank][cnt*WIDTH +: WIDTH] <= wr_data;
      if (do_swap) active_bank <= ~active_bank;
      err <= (err & ~load_start) | (swap & ~bank_ready) | bad_filt;
      kern_valid <= rd_req;
      // the read samples active_bank before any same-cycle swap takes effect
      if (rd_req) kern_data <= bad_filt ? '0 : bank[active_bank][rd_filt*KW*WIDTH +: KW*WIDTH];
    end
`ifdef CONV_WEIGHT_BANK_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chksum <= '0;
    else chksum <= load_start ? '0 : wr_en ? chksum + {{CW{wr_data[WIDTH-1]}}, wr_data} : chksum;
`endif
endmodule

// File: tb/tb_conv_weight_bank.sv
// tb_conv_weight_bank: directed self-checking bench for conv_weight_bank
module tb_conv_weight_bank;
  localparam int W = 17;
  localparam int KW = 27;
  localparam int NW = 108;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0;
  logic wr_valid = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic swap = 1'b0;
  logic rd_req = 1'b0;
  logic [1:0] rd_filt = '0;
  logic wr_ready, kern_valid, bank_ready, active_bank, err;
  logic [KW*W-1:0] kern_data;
`ifdef CONV_WEIGHT_BANK_CHKSUM_EN
  logic [23:0] chksum;
`endif
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  conv_weight_bank dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .swap(swap), .rd_req(rd_req),
    .rd_filt(rd_filt), .kern_valid(kern_valid), .kern_data(kern_data),
    .bank_ready(bank_ready), .active_bank(active_bank), .err(err)
`ifdef CONV_WEIGHT_BANK_CHKSUM_EN
    , .chksum(chksum)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [KW*W-1:0] kern(input int base);
    logic [KW*W-1:0] k;
    for (int j = 0; j < KW; j++) k[j*W +: W] = W'(base + j);
    return k;
  endfunction
  task automatic load(input int base, input int step, input int n, input bit gaps);
    int i;
    bit v;
    i = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    while (i < n) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_valid = v;
      wr_data = v ? W'(base + step*i) : 17'h1ABCD;
      tick();
      if (v) i++;
    end
    wr_valid = 1'b0;
  endtask
  task automatic junk_writes;
    wr_valid = 1'b1;
    wr_data = 17'h1ABCD;
    tick();
    tick();
    wr_valid = 1'b0;
  endtask
  task automatic rd(input logic [1:0] f);
    rd_req = 1'b1;
    rd_filt = f;
    tick();
    rd_req = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_bank_ready", bank_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_active", active_bank, 0);
    chk("rst_kern_valid", kern_valid, 0);
    chk("rst_kern_data", kern_data, 0);
    rst_n = 1'b1;
    tick();
    rd(2'd2);
    chk("rd0_valid", kern_valid, 1);
    chk("rd0_zero", kern_data, 0);
    chk("rd0_active", active_bank, 0);
    tick();
    chk("rd0_pulse", kern_valid, 0);
    load(0, 1, NW, 1'b0);
    chk("full_bank_ready", bank_ready, 1);
    chk("full_wr_ready", wr_ready, 0);
`ifdef CONV_WEIGHT_BANK_CHKSUM_EN
    chk("chksum_ramp", chksum, 24'd5778);
`endif
    junk_writes();
    rd_req = 1'b1;
    rd_filt = 2'd1;
    swap = 1'b1;
    tick();
    rd_req = 1'b0;
    swap = 1'b0;
    chk("rdswap_old", kern_data, 0);
    chk("rdswap_active", active_bank, 1);
    chk("rdswap_idle", bank_ready, 0);
    chk("rdswap_err", err, 0);
    rd(2'd1);
    chk("f1_w000", kern_data[0 +: W], 17'd27);
    chk("f1_w222", kern_data[26*W +: W], 17'd53);
    chk("f1_all", kern_data, kern(27));
    rd_req = 1'b1;
    rd_filt = 2'd0;
    tick();
    chk("b2b_f0", kern_data, kern(0));
    chk("b2b_valid", kern_valid, 1);
    rd_filt = 2'd3;
    tick();
    rd_req = 1'b0;
    chk("b2b_f3", kern_data, kern(81));
    load(0, 1, NW, 1'b1);
    chk("gap_bank_ready", bank_ready, 1);
    chk("gap_active_kept", active_bank, 1);
    junk_writes();
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk("gap_swap_active", active_bank, 0);
    rd(2'd2);
    chk("gap_f2", kern_data, kern(54));
    rd(2'd0);
    chk("gap_f0", kern_data, kern(0));
    load(500, 1, 40, 1'b0);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk("badswap_err", err, 1);
    chk("badswap_active", active_bank, 0);
    chk("badswap_loading", wr_ready, 1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("restart_err_clr", err, 0);
    chk("restart_wr_ready", wr_ready, 1);
    wr_valid = 1'b1;
    for (int i = 0; i < NW - 1; i++) begin
      wr_data = W'(200 + i);
      tick();
    end
    chk("restart_not_full", bank_ready, 0);
    wr_data = W'(200 + NW - 1);
    tick();
    wr_valid = 1'b0;
    chk("restart_full", bank_ready, 1);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    chk("restart_active", active_bank, 1);
    rd(2'd0);
    chk("restart_f0", kern_data, kern(200));
    rd(2'd3);
    chk("restart_f3", kern_data, kern(281));
`ifdef CONV_WEIGHT_BANK_CHKSUM_EN
    load(-1, 0, NW, 1'b0);
    chk("chksum_neg", chksum, 24'hFFFF94);
    chk("chksum_neg_full", bank_ready, 1);
    load(7, 1, 50, 1'b0);
    chk("chksum_partial", chksum, 24'd1575);
    rst_n = 1'b0;
    #2;
    chk("arst_chksum", chksum, 0);
    chk("arst_bank_ready", bank_ready, 0);
    chk("arst_wr_ready", wr_ready, 0);
    chk("arst_active", active_bank, 0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(2'd0);
    chk("arst_bank_zero", kern_data, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
